// File: rtl/nebula_credit_rx_buffer.sv
// Receiver end of the Nebula credit link: DEPTH-entry flit FIFO with one credit pulse per dequeue.
// Optional NEBULA_CREDIT_RX_OVF_CHECK_EN adds a sticky overflow_err flag and a simulation $error.
module nebula_credit_rx_buffer #(
    parameter int DEPTH      = 8,
    parameter int FLIT_WIDTH = 64,
    parameter int CNT_WIDTH  = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [FLIT_WIDTH-1:0] in_data,
    output logic                  out_valid,
    output logic [FLIT_WIDTH-1:0] out_data,
    input  logic                  out_ready,
    output logic                  credit_return,
    output logic [CNT_WIDTH-1:0]  occupancy,
    output logic                  overflow_err
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [FLIT_WIDTH-1:0] mem_q [DEPTH];
    logic [FLIT_WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_WIDTH-1:0]  occ_q, occ_d;
    logic                  credit_q, credit_d;
    logic                  full, push, pop;

    // A full buffer drops the flit even if a pop frees a slot this cycle.
    assign full      = (occ_q == CNT_WIDTH'(DEPTH));
    assign push      = in_valid && !full;
    assign out_valid = (occ_q != '0);
    assign pop       = out_valid && out_ready;

    assign out_data      = mem_q[rd_ptr_q];
    assign occupancy     = occ_q;
    assign credit_return = credit_q;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        credit_d = pop;

        if (push) begin
            mem_d[wr_ptr_q] = in_data;
            wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
        end

        case ({push, pop})
            2'b10:   occ_d = occ_q + CNT_WIDTH'(1);
            2'b01:   occ_d = occ_q - CNT_WIDTH'(1);
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            credit_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            credit_q <= credit_d;
        end
    end

    // Payload storage needs no reset; out_valid gates its use.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

`ifdef NEBULA_CREDIT_RX_OVF_CHECK_EN
    logic ovf_q, ovf_d;

    assign ovf_d        = ovf_q | (in_valid && full);
    assign overflow_err = ovf_q;

    always_ff @(posedge clk) begin
        if (!rst_n) ovf_q <= 1'b0;
        else        ovf_q <= ovf_d;
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (rst_n && in_valid && full)
            $error("nebula_credit_rx_buffer: push while full at %0t, occupancy=%0d", $time, occ_q);
    end
`endif
`else
    assign overflow_err = 1'b0;
`endif

endmodule

// File: tb/tb_nebula_credit_rx_buffer.sv
// Scoreboard bench for nebula_credit_rx_buffer: DEPTH=8 and DEPTH=6 instances share stimulus,
// each checked against a queue model; a closed-loop phase models the credit sender.
module tb_nebula_credit_rx_buffer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [63:0] in_data = '0;
    logic        out_ready = 1'b0;

    int checks = 0;
    int failures = 0;

`ifdef NEBULA_CREDIT_RX_OVF_CHECK_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int D  = (g == 0) ? 8 : 6;
        localparam int CW = $clog2(D + 1);

        logic          ov, cr, oe;
        logic [63:0]   od;
        logic [CW-1:0] occ;

        nebula_credit_rx_buffer #(.DEPTH(D), .FLIT_WIDTH(64)) u_dut (
            .clk           (clk),
            .rst_n         (rst_n),
            .in_valid      (in_valid),
            .in_data       (in_data),
            .out_valid     (ov),
            .out_data      (od),
            .out_ready     (out_ready),
            .credit_return (cr),
            .occupancy     (occ),
            .overflow_err  (oe)
        );

        // Scoreboard: flits accepted by the model wait here until the handshake removes them.
        logic [63:0] sb[$];
        bit cr_exp = 1'b0;
        bit ovf_exp = 1'b0;
        bit live = 1'b0;

        always @(negedge clk) begin
            bit acc;
            bit pop_m;
            if (live) begin
                check($sformatf("d%0d_occupancy", D), 64'(occ), 64'(sb.size()));
                check($sformatf("d%0d_out_valid", D), 64'(ov), 64'(sb.size() != 0));
                check($sformatf("d%0d_credit_return", D), 64'(cr), 64'(cr_exp));
                check($sformatf("d%0d_overflow_err", D), 64'(oe), 64'(ovf_exp));
                if (sb.size() != 0)
                    check($sformatf("d%0d_out_data", D), od, sb[0]);
            end
            // Decide what the coming rising edge does, from inputs held stable across it.
            if (!rst_n) begin
                sb.delete();
                cr_exp  = 1'b0;
                ovf_exp = 1'b0;
                live    = 1'b1;
            end else if (live) begin
                acc   = in_valid && (sb.size() < D);
                pop_m = (sb.size() != 0) && out_ready;
                if (in_valid && !acc && OVF_EN) ovf_exp = 1'b1;
                if (pop_m) void'(sb.pop_front());
                if (acc) sb.push_back(in_data);
                cr_exp = pop_m;
            end
        end
    end

    task automatic step(input logic v, input logic [63:0] d, input logic r);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        @(posedge clk);
        #2;
    endtask

    initial begin
        int credits;
        int nxt;

        // Reset then idle
        rst_n = 1'b0;
        step(0, 0, 0);
        step(0, 0, 0);
        rst_n = 1'b1;
        repeat (3) step(0, 0, 0);

        // Single flit, held then popped
        step(1, 64'hA5, 0);
        step(0, 0, 0);
        step(0, 0, 1);
        step(0, 0, 0);
        step(0, 0, 0);

        // Fill past capacity, then drain
        for (int i = 0; i < 9; i++) step(1, 64'(i), 0);
        step(0, 0, 0);
        repeat (10) step(0, 0, 1);
        step(0, 0, 0);

        // Pointer wrap: 4 in/out, then a full buffer's worth
        for (int i = 0; i < 4; i++) step(1, 64'(100 + i), 0);
        repeat (4) step(0, 0, 1);
        for (int i = 0; i < 6; i++) step(1, 64'(200 + i), 0);
        repeat (6) step(0, 0, 1);
        step(0, 0, 0);

        // Streaming at occupancy 3
        for (int i = 0; i < 3; i++) step(1, 64'(300 + i), 0);
        for (int i = 0; i < 10; i++) step(1, 64'(400 + i), 1);
        repeat (4) step(0, 0, 1);

        // Random traffic
        for (int i = 0; i < 80; i++)
            step(1'($urandom_range(0, 1)), {$urandom, $urandom}, 1'($urandom_range(0, 1)));

        // Reset with data inside
        step(1, 64'h77, 0);
        step(1, 64'h78, 0);
        rst_n = 1'b0;
        step(0, 0, 0);
        rst_n = 1'b1;
        step(0, 0, 0);

        // Closed loop with a sender holding 8 credits
        credits = 8;
        for (int i = 0; i < 200; i++) begin
            in_valid  = (credits > 0);
            in_data   = {$urandom, $urandom};
            out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("loop_credit_sum", 64'(credits + int'(g_dut[0].occ) + int'(g_dut[0].cr)), 64'd8);
            nxt = credits - int'(in_valid) + int'(g_dut[0].cr);
            @(posedge clk);
            #2;
            credits = nxt;
        end
        repeat (12) step(0, 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
